// File: rtl/cc_pkg.sv
// Shared condition-code types and the N/Z/P decode used by the LC-3 CC/BEN unit.
package cc_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_RESET = 3'b010;

  // Callers zero-extend their bus value into value_t and pass the real width.
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] value_t;

  function automatic cc_t nzp_decode(input value_t value, input int width);
    value_t msb;
    cc_t    r;
    msb = value_t'(1) << (width - 1);
    if (value == '0) begin
      r = 3'b010;
    end else if ((value & msb) != '0) begin
      r = 3'b100;
    end else begin
      r = 3'b001;
    end
    return r;
  endfunction

endpackage

// File: rtl/cc_ben_unit_if.sv
// Bus/control handshake between the control FSM (master) and the CC/BEN unit (slave).
interface cc_ben_unit_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] D;
  logic              LD_CC;
  logic              LD_BEN;
  logic [2:0]        IR_nzp;
  logic              CC_PUSH;
  logic              CC_POP;
  logic [2:0]        CC_OUT;
  logic              BEN_OUT;
  logic [CNT_W-1:0]  STACK_CNT;
  logic              STACK_FULL;
  logic              STACK_EMPTY;
  logic              STACK_ERR;

  modport master (
    output D, LD_CC, LD_BEN, IR_nzp, CC_PUSH, CC_POP,
    input  CC_OUT, BEN_OUT, STACK_CNT, STACK_FULL, STACK_EMPTY, STACK_ERR
  );

  modport slave (
    input  D, LD_CC, LD_BEN, IR_nzp, CC_PUSH, CC_POP,
    output CC_OUT, BEN_OUT, STACK_CNT, STACK_FULL, STACK_EMPTY, STACK_ERR
  );

endinterface

// File: rtl/cc_stack.sv
// LIFO save stack for CC values; count updates one cycle after push/pop, pop data is the
// combinational top entry. Simultaneous push+pop is a no-op; illegal ops are flagged, not applied.
module cc_stack
  import cc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  cc_t              wr_dat,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty,
  output logic             pop_vld,
  output cc_t              pop_dat,
  output logic             push_err,
  output logic             pop_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cc_t              mem [2**AW];
  logic             push_ok;
  logic [CNT_W-1:0] cnt_m1;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign push_ok  = push & ~pop & ~full;
  assign pop_vld  = pop & ~push & ~empty;
  assign push_err = push & ~pop & full;
  assign pop_err  = pop & ~push & empty;
  assign cnt_m1   = cnt - CNT_W'(1);
  assign pop_dat  = mem[cnt_m1[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push_ok) begin
      cnt <= cnt + CNT_W'(1);
    end else if (pop_vld) begin
      cnt <= cnt_m1;
    end
  end

  // Contents survive reset; only the count is cleared.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[cnt[AW-1:0]] <= wr_dat;
    end
  end

endmodule

// File: rtl/cc_ben_unit.sv
// LC-3 condition-code register, branch enable and CC save stack; CC/BEN update one cycle after load.
// Define CC_BEN_FORWARD_EN to let a same-cycle LD_BEN see the CC being loaded instead of the old one.
module cc_ben_unit
  import cc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input logic          Clk,
  input logic          Reset,
  cc_ben_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  cc_t              cc_q;
  cc_t              cc_dec;
  cc_t              cc_next;
  cc_t              ben_src;
  logic             ben_q;
  logic             err_q;
  logic [CNT_W-1:0] stk_cnt;
  logic             stk_full;
  logic             stk_empty;
  logic             pop_vld;
  cc_t              pop_dat;
  logic             push_err;
  logic             pop_err;

  cc_stack #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_stack (
    .clk      (Clk),
    .rst      (Reset),
    .push     (bus.CC_PUSH),
    .pop      (bus.CC_POP),
    .wr_dat   (cc_q),
    .cnt      (stk_cnt),
    .full     (stk_full),
    .empty    (stk_empty),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .push_err (push_err),
    .pop_err  (pop_err)
  );

  assign cc_dec = nzp_decode(value_t'(bus.D), DATA_W);

  always_comb begin
    cc_next = cc_q;
    if (pop_vld) begin
      cc_next = pop_dat;
    end else if (bus.LD_CC) begin
      cc_next = cc_dec;
    end
  end

`ifdef CC_BEN_FORWARD_EN
  assign ben_src = cc_next;
`else
  assign ben_src = cc_q;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cc_q  <= CC_RESET;
      ben_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cc_q <= cc_next;
      if (bus.LD_BEN) begin
        ben_q <= |(bus.IR_nzp & ben_src);
      end
      if (push_err || pop_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.CC_OUT      = cc_q;
  assign bus.BEN_OUT     = ben_q;
  assign bus.STACK_CNT   = stk_cnt;
  assign bus.STACK_FULL  = stk_full;
  assign bus.STACK_EMPTY = stk_empty;
  assign bus.STACK_ERR   = err_q;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Randomized + directed bench for cc_ben_unit against a queue-based reference model.
module tb_cc_ben_unit;

  localparam int DEPTH = 4;
`ifdef CC_BEN_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  cc_ben_unit_if #(.DATA_W(16), .DEPTH(DEPTH)) bus ();
  cc_ben_unit_if #(.DATA_W(8),  .DEPTH(DEPTH)) bus8 ();

  cc_ben_unit #(.DATA_W(16), .DEPTH(DEPTH)) dut  (.Clk(Clk), .Reset(Reset), .bus(bus));
  cc_ben_unit #(.DATA_W(8),  .DEPTH(DEPTH)) dut8 (.Clk(Clk), .Reset(Reset), .bus(bus8));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: CC/BEN/error flags plus the saved CCs as a queue (back = top).
  logic [2:0] m_cc;
  logic       m_ben;
  logic       m_err;
  logic [2:0] m_stk[$];

  function automatic logic [2:0] ref_nzp(input logic [15:0] d);
    if (d == 16'd0)          return 3'b010;
    else if (d >= 16'h8000)  return 3'b100;
    else                     return 3'b001;
  endfunction

  task automatic model_step(input bit rst, input logic [15:0] d, input bit ld_cc, input bit ld_ben,
                            input logic [2:0] ir, input bit push, input bit pop);
    logic [2:0] nxt;
    bit popped;
    popped = 1'b0;
    if (rst) begin
      m_cc  = 3'b010;
      m_ben = 1'b0;
      m_err = 1'b0;
      m_stk.delete();
      return;
    end
    nxt = m_cc;
    if (push && !pop) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back(m_cc);
    end
    if (pop && !push) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else begin
        nxt    = m_stk.pop_back();
        popped = 1'b1;
      end
    end
    if (!popped && ld_cc) nxt = ref_nzp(d);
    if (ld_ben) m_ben = |(ir & (FWD ? nxt : m_cc));
    m_cc = nxt;
  endtask

  task automatic step(input bit rst, input logic [15:0] d, input bit ld_cc, input bit ld_ben,
                      input logic [2:0] ir, input bit push, input bit pop);
    Reset       = rst;
    bus.D       = d;
    bus.LD_CC   = ld_cc;
    bus.LD_BEN  = ld_ben;
    bus.IR_nzp  = ir;
    bus.CC_PUSH = push;
    bus.CC_POP  = pop;
    @(posedge Clk);
    model_step(rst, d, ld_cc, ld_ben, ir, push, pop);
    @(negedge Clk);
    check_val("cc",    32'(bus.CC_OUT),      32'(m_cc));
    check_val("ben",   32'(bus.BEN_OUT),     32'(m_ben));
    check_val("cnt",   32'(bus.STACK_CNT),   32'(m_stk.size()));
    check_val("full",  32'(bus.STACK_FULL),  32'(m_stk.size() == DEPTH));
    check_val("empty", 32'(bus.STACK_EMPTY), 32'(m_stk.size() == 0));
    check_val("err",   32'(bus.STACK_ERR),   32'(m_err));
  endtask

  initial begin
    logic [15:0] d;
    bus8.D = '0; bus8.LD_CC = 1'b0; bus8.LD_BEN = 1'b0;
    bus8.IR_nzp = '0; bus8.CC_PUSH = 1'b0; bus8.CC_POP = 1'b0;

    // Reset state
    step(1, 16'h0000, 0, 0, 3'b000, 0, 0);
    check_val("rst_cc",  32'(bus.CC_OUT), 32'(3'b010));
    check_val("rst_ben", 32'(bus.BEN_OUT), 32'd0);
    check_val("rst_cnt", 32'(bus.STACK_CNT), 32'd0);

    // NZP decode
    step(0, 16'h0000, 1, 0, 3'b000, 0, 0);  check_val("dec_zero", 32'(bus.CC_OUT), 32'(3'b010));
    step(0, 16'h8001, 1, 0, 3'b000, 0, 0);  check_val("dec_neg",  32'(bus.CC_OUT), 32'(3'b100));
    step(0, 16'h7FFF, 1, 0, 3'b000, 0, 0);  check_val("dec_pos",  32'(bus.CC_OUT), 32'(3'b001));

    // 8-bit instance: sign bit is bit 7
    bus8.D = 8'h80; bus8.LD_CC = 1'b1;
    step(0, 16'h0000, 0, 0, 3'b000, 0, 0);  check_val("dec8_neg", 32'(bus8.CC_OUT), 32'(3'b100));
    bus8.D = 8'h7F;
    step(0, 16'h0000, 0, 0, 3'b000, 0, 0);  check_val("dec8_pos", 32'(bus8.CC_OUT), 32'(3'b001));
    bus8.LD_CC = 1'b0;

    // BEN evaluation with CC=001
    step(0, 16'h0000, 0, 1, 3'b011, 0, 0);  check_val("ben_match", 32'(bus.BEN_OUT), 32'd1);
    step(0, 16'h0000, 0, 1, 3'b100, 0, 0);  check_val("ben_miss",  32'(bus.BEN_OUT), 32'd0);
    step(0, 16'h0000, 0, 1, 3'b011, 0, 0);
    step(0, 16'h0000, 0, 0, 3'b000, 0, 0);  check_val("ben_hold",  32'(bus.BEN_OUT), 32'd1);
    step(0, 16'h0000, 0, 1, 3'b000, 0, 0);  check_val("ben_nomask", 32'(bus.BEN_OUT), 32'd0);

    // Same-cycle LD_CC + LD_BEN from CC=100
    step(0, 16'h8001, 1, 0, 3'b000, 0, 0);
    step(0, 16'h0000, 1, 1, 3'b010, 0, 0);  check_val("ben_fwd", 32'(bus.BEN_OUT), 32'(FWD));

    // Fill stack with 100,010,001,100 then overflow
    step(0, 16'h8000, 1, 0, 3'b000, 0, 0);
    step(0, 16'h0000, 1, 0, 3'b000, 1, 0);
    step(0, 16'h0001, 1, 0, 3'b000, 1, 0);
    step(0, 16'h8000, 1, 0, 3'b000, 1, 0);
    step(0, 16'h0000, 0, 0, 3'b000, 1, 0);  check_val("full_flag", 32'(bus.STACK_FULL), 32'd1);
    step(0, 16'h0000, 0, 0, 3'b000, 1, 0);  check_val("ovf_err",   32'(bus.STACK_ERR),  32'd1);
    check_val("ovf_cnt", 32'(bus.STACK_CNT), 32'd4);
    step(0, 16'h0000, 0, 0, 3'b000, 0, 1);  check_val("pop1", 32'(bus.CC_OUT), 32'(3'b100));
    step(0, 16'h0000, 0, 0, 3'b000, 0, 1);  check_val("pop2", 32'(bus.CC_OUT), 32'(3'b001));
    step(0, 16'h0000, 0, 0, 3'b000, 0, 1);  check_val("pop3", 32'(bus.CC_OUT), 32'(3'b010));
    step(0, 16'h0000, 0, 0, 3'b000, 0, 1);  check_val("pop4", 32'(bus.CC_OUT), 32'(3'b100));
    step(0, 16'h0000, 0, 0, 3'b000, 0, 1);  check_val("udf_cc", 32'(bus.CC_OUT), 32'(3'b100));

    // Push with LD_CC, then push+pop together
    step(1, 16'h0000, 0, 0, 3'b000, 0, 0);
    step(0, 16'h0001, 1, 0, 3'b000, 0, 0);
    step(0, 16'hFFFF, 1, 0, 3'b000, 1, 0);  check_val("pushld_cc", 32'(bus.CC_OUT), 32'(3'b100));
    step(0, 16'h0000, 0, 0, 3'b000, 1, 1);  check_val("pp_cnt", 32'(bus.STACK_CNT), 32'd1);
    check_val("pp_err", 32'(bus.STACK_ERR), 32'd0);
    step(0, 16'h0000, 0, 0, 3'b000, 0, 1);  check_val("pushld_top", 32'(bus.CC_OUT), 32'(3'b001));

    // Reset mid-activity with CNT=3, ERR=1, BEN=1 and a pop requested
    step(0, 16'h0000, 0, 1, 3'b001, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 0, 0, 3'b000, 1, 0);
    step(0, 16'h0000, 0, 0, 3'b000, 0, 1);
    check_val("pre_rst_cnt", 32'(bus.STACK_CNT), 32'd3);
    step(1, 16'h0000, 0, 0, 3'b000, 0, 1);
    check_val("rst_pop_cnt", 32'(bus.STACK_CNT), 32'd0);
    check_val("rst_pop_err", 32'(bus.STACK_ERR), 32'd0);
    check_val("rst_pop_cc",  32'(bus.CC_OUT), 32'(3'b010));
    check_val("rst_pop_ben", 32'(bus.BEN_OUT), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 16'h0000;
        1:       d = 16'h8000 | 16'($urandom);
        2:       d = 16'h7FFF & 16'($urandom);
        default: d = 16'($urandom);
      endcase
      step($urandom_range(0, 59) == 0, d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           3'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_ben_unit.md
Name: cc_ben_unit

Overview:
- Parametrised condition-code and branch-enable unit for the LC-3 datapath.
- Derives N/Z/P from a DATA_W-wide bus value, holds the CC register, and evaluates BEN against IR[11:9].
- Adds a LIFO save/restore stack for CC, used on interrupt entry (push) and RTI (pop), with full/empty/error status.
- Sits between the bus/ALU result and the control FSM.

Parameters:
- DATA_W, 16, width of the bus value D; must be ≥ 2.
- DEPTH, 4, number of CC entries the save stack holds; must be ≥ 1.
- CNT_W, $clog2(DEPTH+1), width of the stack occupancy count (derived; do not override).

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- D  in  DATA_W  value driven on the bus
- LD_CC  in  1  load CC from D this cycle
- LD_BEN  in  1  load BEN from IR_nzp & CC this cycle
- IR_nzp  in  3  IR[11:9] branch condition mask {n,z,p}
- CC_PUSH  in  1  save current CC onto stack
- CC_POP  in  1  restore CC from top of stack
- CC_OUT  out  3  registered CC {n,z,p}
- BEN_OUT  out  1  registered branch enable
- STACK_CNT  out  CNT_W  current stack occupancy
- STACK_FULL  out  1  STACK_CNT == DEPTH
- STACK_EMPTY  out  1  STACK_CNT == 0
- STACK_ERR  out  1  sticky overflow/underflow flag

Behaviour:
- Reset: Reset is synchronous and active-high on Clk.
  - CC_OUT=3'b010 (Z), BEN_OUT=0, STACK_CNT=0, STACK_ERR=0.
  - Stack contents are not cleared.
  - Reset overrides every other input in the same cycle, including mid push/pop.
- NZP decode (combinational, internal), exactly one-hot:
  - D==0 → 010.
  - D[DATA_W-1]==1 → 100.
  - Otherwise → 001.
- CC register: next-value priority Reset > valid pop > LD_CC > hold.
  - Valid pop: STACK_EMPTY=0 and CC_PUSH=0.
- BEN:
  - On LD_BEN, BEN_OUT <= |(IR_nzp & CC_src), one-cycle latency.
  - CC_src is the registered CC_OUT (see Optional Feature).
  - BEN_OUT holds when LD_BEN=0.
  - IR_nzp=000 always yields 0.
- Stack (LIFO):
  - Push: mem[CNT] <= CC_OUT (pre-update value), CNT+1.
  - Pop: CC <= mem[CNT-1], CNT-1.
  - Push together with LD_CC: the old CC is saved and the new CC loads.
- Boundary conditions:
  - Push when full: write dropped, CNT unchanged, STACK_ERR <= 1.
  - Pop when empty: CC follows LD_CC/hold, CNT unchanged, STACK_ERR <= 1.
  - CC_PUSH and CC_POP in the same cycle: stack and CC unchanged by stack ops (LD_CC still applies), no error.
  - STACK_ERR clears only on Reset.
- STACK_FULL and STACK_EMPTY are combinational decodes of the registered STACK_CNT.

Optional Feature:
- Macro: CC_BEN_FORWARD_EN.
- Defined: when LD_CC and LD_BEN are asserted in the same cycle, BEN uses the freshly decoded NZP of D (or the popped CC if a valid pop occurs). This allows a single-cycle LD.CC+LD.BEN state.
- Undefined: BEN always uses the registered CC_OUT, so the new flags affect BEN only from the next LD_BEN.

Decomposition:
- Package cc_pkg:
  - typedef cc_t: packed struct {n,z,p}.
  - Constant CC_RESET = 3'b010.
  - Function nzp_decode(value, width) → cc_t.
- Sub-module cc_stack: LIFO storage of cc_t, DEPTH entries.
  - Owns mem, CNT, FULL/EMPTY and push/pop legality.
  - Reports the accepted pop and its data to the parent.
  - Parent owns the CC register, BEN and the STACK_ERR set logic.

Test Plan:
- Reset, then D=16'h0000 LD_CC → CC_OUT=010; D=16'h8001 LD_CC → 100; D=16'h7FFF LD_CC → 001. With DATA_W=8, D=8'h80 → 100.
- CC=001, IR_nzp=011, LD_BEN → BEN_OUT=1 next cycle; IR_nzp=100 → 0; IR_nzp=000 → 0; LD_BEN low → BEN holds.
- Same-cycle LD_CC (D=0) + LD_BEN (IR_nzp=010) from CC=100: without macro BEN_OUT=0; with CC_BEN_FORWARD_EN BEN_OUT=1.
- DEPTH=4: push CC values 100,010,001,100 → STACK_FULL=1, CNT=4. 5th push → STACK_ERR=1, CNT=4. Four pops restore 100,001,010,100 in order; 5th pop → CC unchanged, ERR stays 1.
- Push+LD_CC same cycle (CC=001, D=16'hFFFF) → CC=100, top of stack=001. Push+pop same cycle → CNT and CC unchanged, ERR=0.
- Reset asserted with CNT=3, STACK_ERR=1 and CC_POP=1 → CNT=0, ERR=0, CC=010, BEN=0.
